// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel filter datapath: image geometry, pixel
// layout and the pixel feeder state encoding. The filter, the feeder and the
// result collector all import this so they agree on frame size.
package sobel_pkg;

  localparam int SOBEL_IMG_W  = 256;
  localparam int SOBEL_IMG_H  = 256;
  localparam int SOBEL_ADDR_W = 16;
  localparam int SOBEL_DATA_W = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } feeder_state_t;

  // Number of pixels in one frame, used to find the last linear address.
  function automatic int frame_pixels(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/sobel_pixel_feeder_if.sv
// Bus bundle between the pixel feeder, its frame memory and the Sobel filter
// input channel.
//   mem_rd_en / mem_addr : read strobe and linear address to the memory
//   mem_rd_data          : memory data, valid the cycle after mem_rd_en
//   rgb_vld / rgb_data   : pixel offered to the filter
//   rgb_busy             : filter cannot accept this cycle
// modport master is the feeder side, modport slave is the memory/filter side.
interface sobel_pixel_feeder_if
  import sobel_pkg::*;
#(
  parameter int ADDR_W = SOBEL_ADDR_W,
  parameter int DATA_W = SOBEL_DATA_W
) ();

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              rgb_vld;
  logic [DATA_W-1:0] rgb_data;
  logic              rgb_busy;

  modport master (
    output mem_rd_en,
    output mem_addr,
    input  mem_rd_data,
    output rgb_vld,
    output rgb_data,
    input  rgb_busy
  );

  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    output mem_rd_data,
    input  rgb_vld,
    input  rgb_data,
    output rgb_busy
  );

endinterface

// File: rtl/sobel_pixel_feeder_skid_fifo.sv
// p2p_skid_fifo2: two-entry register FIFO that soaks up the one-cycle memory
// read latency in front of the filter handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data this edge (caller guarantees count < 2)
//   pop        : drop the head entry this edge (caller guarantees count > 0)
//   count      : number of stored entries, 0..2
//   head       : oldest entry, straight from a register
module p2p_skid_fifo2
  import sobel_pkg::*;
#(
  parameter int DATA_W = SOBEL_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] head,
  output logic [DATA_W-1:0] tail_unused_guard
);

  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] tail_q;
  logic [1:0]        count_q;

  // The head entry always lives in head_q so the output is a flop. A pop
  // shifts the tail forward; a push lands in the first free slot, which is
  // the head slot when the FIFO is empty or is being emptied by the same pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_q  <= push_data;
            count_q <= 2'd1;
          end else if (count_q == 2'd1) begin
            tail_q  <= push_data;
            count_q <= 2'd2;
          end
        end
        2'b01: begin
          if (count_q != 2'd0) begin
            head_q  <= tail_q;
            count_q <= count_q - 2'd1;
          end
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= push_data;
          end else begin
            head_q  <= push_data;
            count_q <= 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign count             = count_q;
  assign head              = head_q;
  assign tail_unused_guard = tail_q;

endmodule

// File: rtl/sobel_pixel_feeder.sv
// sobel_pixel_feeder: on a start request, reads one IMG_W x IMG_H RGB frame in
// raster order from a synchronous-read memory and streams it to the Sobel
// filter over the vld/busy handshake at up to one pixel per clock.
//   i_clk    : clock, rising edge
//   i_rst    : asynchronous active-low reset
//   i_start  : frame start request, only taken while idle
//   bus      : memory read port and filter pixel channel (master side)
//   o_active : high from leaving IDLE until the DONE cycle inclusive
//   o_done   : one-cycle pulse once the last pixel has been accepted
module sobel_pixel_feeder
  import sobel_pkg::*;
#(
  parameter int IMG_W  = SOBEL_IMG_W,
  parameter int IMG_H  = SOBEL_IMG_H,
  parameter int ADDR_W = SOBEL_ADDR_W,
  parameter int DATA_W = SOBEL_DATA_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  sobel_pixel_feeder_if.master bus,
  output logic                 o_active,
  output logic                 o_done
);

  localparam int                NPIX      = frame_pixels(IMG_W, IMG_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  feeder_state_t     state_q;
  feeder_state_t     state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              inflight_q;
  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic [DATA_W-1:0] fifo_tail;
  logic              pop;
  logic              rd_en;
  logic [2:0]        occupancy;

  // Slots already claimed once this edge's transfer is accounted for: entries
  // held, plus the read still in flight, minus the one leaving now. Issuing
  // only below two keeps the FIFO from ever being pushed while full.
  assign pop       = (fifo_count != 2'd0) & ~bus.rgb_busy;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

  // Next-state and output decode. DRAIN waits for both the FIFO and the
  // outstanding read to empty so the done pulse follows the final transfer.
  always_comb begin
    state_d  = state_q;
    rd_en    = 1'b0;
    o_active = 1'b0;
    o_done   = 1'b0;
    if (state_q == RUN && occupancy < 3'd2) begin
      rd_en = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        o_active = 1'b1;
        if (rd_en && addr_q == LAST_ADDR) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        o_active = 1'b1;
        if (fifo_count == 2'd0 && !inflight_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        o_active = 1'b1;
        o_done   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register, address counter and read-in-flight flag. The address is
  // cleared when a frame is accepted and advances with every issued read.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_en;
      if (state_q == IDLE && i_start) begin
        addr_q <= '0;
      end else if (rd_en) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

  p2p_skid_fifo2 #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk               (i_clk),
    .rst_n             (i_rst),
    .push              (inflight_q),
    .push_data         (bus.mem_rd_data),
    .pop               (pop),
    .count             (fifo_count),
    .head              (fifo_head),
    .tail_unused_guard (fifo_tail)
  );

  assign bus.mem_rd_en = rd_en;
  assign bus.mem_addr  = addr_q;
  assign bus.rgb_vld   = (fifo_count != 2'd0);
  assign bus.rgb_data  = fifo_head;

  logic unused_tail;
  assign unused_tail = ^fifo_tail;

endmodule

// File: tb/tb_sobel_pixel_feeder.sv
// Testbench for sobel_pixel_feeder on a 4x2 frame whose memory holds
// 0x100000 + address. A scoreboard process tracks the expected pixel order,
// FIFO occupancy and handshake rules every cycle; the stimulus process adds
// directed timing expectations for each scenario.
module tb_sobel_pixel_feeder;

  localparam int          IMG_W      = 4;
  localparam int          IMG_H      = 2;
  localparam int          NPIX       = IMG_W * IMG_H;
  localparam int          ADDR_W     = 16;
  localparam int          DATA_W     = 24;
  localparam logic [23:0] PIXEL_BASE = 24'h100000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic active;
  logic done;

  int checks   = 0;
  int failures = 0;

  int done_count  = 0;
  int xfer_total  = 0;

  sobel_pixel_feeder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sobel_pixel_feeder #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst_n),
    .i_start  (start),
    .bus      (bus),
    .o_active (active),
    .o_done   (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read frame memory: every location holds 0x100000 + address.
  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      bus.mem_rd_data <= PIXEL_BASE + 24'(bus.mem_addr);
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle: pixels must arrive in memory order, a stalled pixel must
  // stay put, vld must match the number of reads returned but not yet taken,
  // that number must never exceed two, and done must close a full frame.
  initial begin
    int          cycle_num = 0;
    int          model_count = 0;
    int          exp_idx = 0;
    int          issue_idx = 0;
    int          last_xfer_cycle = 0;
    bit          rd_prev1 = 0;
    bit          rd_prev2 = 0;
    bit          xfer_prev = 0;
    bit          hold_prev = 0;
    bit          xfer_now;
    logic [23:0] held_data = '0;
    forever begin
      @(negedge clk);
      cycle_num++;
      if (!rst_n) begin
        model_count = 0;
        exp_idx     = 0;
        issue_idx   = 0;
        rd_prev1    = 0;
        rd_prev2    = 0;
        xfer_prev   = 0;
        hold_prev   = 0;
      end else begin
        model_count = model_count + (rd_prev2 ? 1 : 0) - (xfer_prev ? 1 : 0);
        check_output("fifo_level_max2", 32'(model_count <= 2), 32'd1);
        check_output("vld_vs_level", bus.rgb_vld, 32'(model_count != 0));
        if (hold_prev) begin
          check_output("vld_held", bus.rgb_vld, 32'd1);
          check_output("data_held", bus.rgb_data, held_data);
        end
        if (bus.rgb_vld) begin
          check_output("pixel_order", bus.rgb_data, PIXEL_BASE + 24'(exp_idx));
        end
        if (bus.mem_rd_en) begin
          check_output("issue_addr", bus.mem_addr, issue_idx);
          issue_idx++;
        end
        if (done) begin
          check_output("done_after_all", exp_idx, NPIX);
          check_output("done_latency", cycle_num - last_xfer_cycle, 32'd2);
          done_count++;
          exp_idx   = 0;
          issue_idx = 0;
        end
        xfer_now = bus.rgb_vld & ~bus.rgb_busy;
        if (xfer_now) begin
          exp_idx++;
          xfer_total++;
          last_xfer_cycle = cycle_num;
        end
        hold_prev = bus.rgb_vld & bus.rgb_busy;
        held_data = bus.rgb_data;
        rd_prev2  = rd_prev1;
        rd_prev1  = bus.mem_rd_en;
        xfer_prev = xfer_now;
      end
    end
  end

  // Pulse start for one cycle; returns #1 after the edge that samples it.
  task automatic apply_stimulus();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_rd_en"}, bus.mem_rd_en, 32'd0);
    check_output({tag, "_addr"}, bus.mem_addr, 32'd0);
    check_output({tag, "_vld"}, bus.rgb_vld, 32'd0);
    check_output({tag, "_data"}, bus.rgb_data, 32'd0);
    check_output({tag, "_active"}, active, 32'd0);
    check_output({tag, "_done"}, done, 32'd0);
  endtask

  // Drive one frame after the start edge E0. Iteration k covers cycle
  // Ek..Ek+1. mode 0: no backpressure, 1: busy for cycles 2..6,
  // 2: random busy, 3: stray start pulses during RUN and DRAIN.
  task automatic run_frame(input int mode, output int done_k);
    done_k = -1;
    for (int k = 0; k < 100; k++) begin
      case (mode)
        1:       bus.rgb_busy = (k >= 2 && k <= 6);
        2:       bus.rgb_busy = 1'($urandom_range(0, 1));
        default: bus.rgb_busy = 1'b0;
      endcase
      start = (mode == 3 && (k == 4 || k == 9));
      @(negedge clk);
      if (k == 0) begin
        check_output("first_rd_en", bus.mem_rd_en, 32'd1);
        check_output("first_addr", bus.mem_addr, 32'd0);
        check_output("active_run", active, 32'd1);
      end
      if (k == 1) begin
        check_output("vld_not_yet", bus.rgb_vld, 32'd0);
      end
      if (k == 2) begin
        check_output("first_vld", bus.rgb_vld, 32'd1);
        check_output("first_data", bus.rgb_data, 32'h100000);
      end
      if (mode == 1 && k >= 2 && k <= 6) begin
        check_output("stall_vld", bus.rgb_vld, 32'd1);
        check_output("stall_data", bus.rgb_data, 32'h100000);
        check_output("stall_rd_en", bus.mem_rd_en, 32'd0);
        check_output("stall_addr", bus.mem_addr, 32'd2);
      end
      if (done) begin
        done_k = k;
        check_output("active_done", active, 32'd1);
        break;
      end
      @(posedge clk);
      #1;
    end
    bus.rgb_busy = 1'b0;
    start        = 1'b0;
    if (done_k < 0) begin
      check_output("done_timeout", 32'd0, 32'd1);
    end
  endtask

  initial begin
    int dk;
    int d0;
    int x0;
    bus.rgb_busy = 1'b0;
    rst_n        = 1'b0;
    start        = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] frame with no backpressure");
    apply_stimulus();
    run_frame(0, dk);
    check_output("plain_done_cycle", dk, 32'd11);

    $display("[TB] back-to-back frame started the cycle after done");
    apply_stimulus();
    run_frame(0, dk);
    check_output("b2b_done_cycle", dk, 32'd11);

    $display("[TB] five-cycle stall on the first pixel");
    apply_stimulus();
    run_frame(1, dk);
    check_output("stall_done_cycle", dk, 32'd16);

    $display("[TB] three back-to-back frames with random busy");
    d0 = done_count;
    x0 = xfer_total;
    for (int f = 0; f < 3; f++) begin
      apply_stimulus();
      run_frame(2, dk);
    end
    check_output("random_frames", done_count - d0, 32'd3);
    check_output("random_pixels", xfer_total - x0, 32'd24);

    $display("[TB] start pulses during RUN and DRAIN");
    d0 = done_count;
    apply_stimulus();
    run_frame(3, dk);
    check_output("stray_start_done_cycle", dk, 32'd11);
    repeat (12) @(negedge clk);
    check_output("stray_start_one_done", done_count - d0, 32'd1);
    check_output("stray_start_idle", active, 32'd0);

    $display("[TB] reset after three transfers");
    d0 = done_count;
    x0 = xfer_total;
    apply_stimulus();
    repeat (5) @(posedge clk);
    #1;
    check_output("pre_reset_xfers", xfer_total - x0, 32'd3);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_output("no_done_after_reset", done_count - d0, 32'd0);
    check_output("idle_after_reset", active, 32'd0);
    apply_stimulus();
    run_frame(0, dk);
    check_output("restart_done_cycle", dk, 32'd11);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
